// File: rtl/six_to_one_capture.sv
`default_nettype none
// ============================================================================
// Module   : six_to_one_capture
// Purpose  : Capture stage for the six-to-one gate network. Accepts 8-bit X
//            results on a valid/ready handshake into a small FIFO, optionally
//            drops beats repeating the last accepted value, and presents the
//            buffered results on a second valid/ready handshake.
// Options  : SIX_TO_ONE_CAP_PARITY_EN adds a stored even-parity bit per entry
//            and the out_parity port.
// Revision : 1.0 - initial release
// ============================================================================
module six_to_one_capture #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_x,
    input  logic          dedup_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [CW-1:0] level,
    output logic [7:0]    dup_cnt
`ifdef SIX_TO_ONE_CAP_PARITY_EN
    ,
    output logic          out_parity
`endif
);

    localparam int AW = $clog2(DEPTH);
`ifdef SIX_TO_ONE_CAP_PARITY_EN
    localparam int W  = 9;
`else
    localparam int W  = 8;
`endif

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    last_x;
    logic          last_vld;

    logic          accept;
    logic          pop;
    logic          dup;
    logic          push;
    logic [W-1:0]  wdata;
    logic [W-1:0]  head;

    // Handshake flags come only from the registered occupancy, so out_ready
    // never reaches in_ready combinationally.
    assign in_ready  = (level != CW'(DEPTH));
    assign out_valid = (level != '0);

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;
    assign dup    = dedup_en & last_vld & (in_x == last_x);
    assign push   = accept & ~dup;

`ifdef SIX_TO_ONE_CAP_PARITY_EN
    assign wdata      = {^in_x, in_x};
`else
    assign wdata      = in_x;
`endif

    assign head     = mem[rd_ptr];
    assign out_data = out_valid ? head[7:0] : 8'h00;
`ifdef SIX_TO_ONE_CAP_PARITY_EN
    assign out_parity = out_valid ? head[8] : 1'b0;
`endif

    // Entry storage; left unreset since unread entries are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase
        end
    end

    // Last-accepted-value tracker and saturating duplicate counter. The
    // tracker updates on every accept, whether or not dedup is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_x   <= 8'h00;
            last_vld <= 1'b0;
            dup_cnt  <= 8'h00;
        end else begin
            if (accept) begin
                last_x   <= in_x;
                last_vld <= 1'b1;
            end
            if (accept && dup && (dup_cnt != 8'hFF)) begin
                dup_cnt <= dup_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_six_to_one_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_six_to_one_capture
// Purpose  : Self-checking bench for six_to_one_capture: directed scenarios
//            followed by random traffic, compared against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_six_to_one_capture;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_x;
    logic          dedup_en;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [CW-1:0] level;
    logic [7:0]    dup_cnt;
`ifdef SIX_TO_ONE_CAP_PARITY_EN
    logic          out_parity;
`endif

    six_to_one_capture #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .dedup_en  (dedup_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .dup_cnt   (dup_cnt)
`ifdef SIX_TO_ONE_CAP_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the buffered results as a plain queue.
    logic [7:0] q[$];
    logic [7:0] m_last;
    bit         m_last_vld;
    int         m_dup;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last     = 8'h00;
        m_last_vld = 1'b0;
        m_dup      = 0;
    endtask

    // Compare every observable output with the model.
    task automatic check_all(input string tag);
        check_val({tag, ".level"},     32'(level),     32'(q.size()));
        check_val({tag, ".in_ready"},  32'(in_ready),  32'(q.size() != DEPTH));
        check_val({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        check_val({tag, ".out_data"},  32'(out_data),  32'(q.size() != 0 ? q[0] : 8'h00));
        check_val({tag, ".dup_cnt"},   32'(dup_cnt),   32'(m_dup));
`ifdef SIX_TO_ONE_CAP_PARITY_EN
        check_val({tag, ".parity"},    32'(out_parity), 32'(q.size() != 0 ? ^q[0] : 1'b0));
`endif
    endtask

    // One clock: apply the handshake rules to the model, then compare.
    task automatic step(input string tag);
        bit acc;
        bit pp;
        acc = in_valid && (q.size() != DEPTH);
        pp  = out_ready && (q.size() != 0);
        @(posedge clk);
        if (pp) void'(q.pop_front());
        if (acc) begin
            if (dedup_en && m_last_vld && in_x == m_last) begin
                if (m_dup < 255) m_dup++;
            end else begin
                q.push_back(in_x);
            end
            m_last     = in_x;
            m_last_vld = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step("drain");
    endtask

    initial begin
        logic [7:0] vals [4];
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_x      = 8'h00;
        dedup_en  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Single beat after reset.
        in_valid = 1'b1; in_x = 8'hA5; dedup_en = 1'b0; out_ready = 1'b0;
        step("single");
        check_val("single.data_const", 32'(out_data), 32'h0000_00A5);
        check_val("single.level_const", 32'(level), 32'd1);
        drain();

        // Fill to full, offer a fifth beat, then pop once.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_x = 8'(i);
            step("fill");
        end
        check_val("full.level_const", 32'(level), 32'd4);
        check_val("full.in_ready_const", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_val("full.head_const", 32'(out_data), 32'h0000_0001);
        step("pop1");
        check_val("pop1.in_ready_const", 32'(in_ready), 32'd1);
        drain();

        // Streaming with continuous pops: pointers wrap repeatedly.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_x = 8'h10 + 8'(i);
            step("stream");
            check_val("stream.level_le1", 32'(level <= 1), 32'd1);
        end
        drain();

        // Dedup enabled, then disabled with the same sequence.
        vals[0] = 8'h3C; vals[1] = 8'h3C; vals[2] = 8'h3C; vals[3] = 8'hC3;
        dedup_en = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_x = vals[i];
            step("dedup");
        end
        check_val("dedup.cnt_const", 32'(dup_cnt), 32'd2);
        dedup_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_x = vals[i];
            step("nodedup");
        end
        check_val("nodedup.cnt_const", 32'(dup_cnt), 32'd2);
        drain();

        // Saturation of the duplicate counter.
        dedup_en = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_x = 8'h00;
        for (int i = 0; i < 300; i++) step("sat");
        check_val("sat.cnt_const", 32'(dup_cnt), 32'h0000_00FF);
        drain();

        // Reset with three entries buffered.
        dedup_en = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        vals[0] = 8'h3C; vals[1] = 8'h11; vals[2] = 8'h22;
        for (int i = 0; i < 3; i++) begin
            in_x = vals[i];
            step("pre_rst");
        end
        check_val("pre_rst.level_const", 32'(level), 32'd3);
        in_valid = 1'b0;
        do_reset();
        check_val("rst.level_const", 32'(level), 32'd0);
        in_valid = 1'b1; in_x = 8'h3C; dedup_en = 1'b1;
        step("post_rst");
        check_val("post_rst.level_const", 32'(level), 32'd1);
        drain();

        // Random traffic over a small value set so duplicates are frequent.
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 1));
            dedup_en  = 1'($urandom_range(0, 1));
            in_x      = 8'($urandom_range(0, 3)) ^ 8'hA0;
            step("rand");
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
